// File: rtl/conv_in_dispatcher.sv
// conv_in_dispatcher: buffers IFM/weight streams in FIFOs and answers CONV_ACC reads with zero latency
//   ports: clk, rst_n (sync, active-low); start_conv + ifm_words/wgt_words program a conv;
//   ifm_s_*/wgt_s_* upstream valid/ready fill; ifm_read/ifm and wgt_read/weight serve CONV_ACC;
//   busy (RUN), done (one-cycle pulse), underflow (sticky bad read).
//   Optional macro DISP_BYPASS_EN: empty-FIFO reads take upstream data straight through.
module conv_in_chan #(
    parameter int W  = 64,
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          run,
    input  logic [CW-1:0] len_in,
    input  logic [W-1:0]  s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          read,
    output logic [W-1:0]  dout,
    output logic          all_served,
    output logic          uflow
);
    logic [W-1:0]  mem [2**AW];
    logic [AW:0]   wp, rp;
    logic [CW-1:0] len, acc, srv;
    logic          full, empty, pop, push, byp;

    assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty      = wp == rp;
    assign all_served = srv == len;
    // bypass only happens on an empty FIFO, where accepted==served, so the
    // regular ready term is already 1 whenever bypass fires
    assign s_ready    = run && !full && (acc < len);
`ifdef DISP_BYPASS_EN
    assign byp        = run && read && empty && s_valid && (srv < len);
`else
    assign byp        = 1'b0;
`endif
    assign pop        = run && read && !empty && (srv < len);
    assign push       = s_valid && s_ready && !byp;
    assign dout       = pop ? mem[rp[AW-1:0]] : byp ? s_data : '0;
    assign uflow      = run && read && !pop && !byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            len <= '0;
            acc <= '0;
            srv <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            len <= len_in;
            acc <= '0;
            srv <= '0;
        end else begin
            if (push)        wp  <= wp + 1'b1;
            if (pop)         rp  <= rp + 1'b1;
            if (push || byp) acc <= acc + 1'b1;
            if (pop || byp)  srv <= srv + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= s_data;
    end
endmodule

module conv_in_dispatcher #(
    parameter int IFM_W   = 64,
    parameter int WGT_W   = 32,
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_conv,
    input  logic [CNT_W-1:0] ifm_words,
    input  logic [CNT_W-1:0] wgt_words,
    input  logic [IFM_W-1:0] ifm_s_data,
    input  logic             ifm_s_valid,
    output logic             ifm_s_ready,
    input  logic [WGT_W-1:0] wgt_s_data,
    input  logic             wgt_s_valid,
    output logic             wgt_s_ready,
    input  logic             ifm_read,
    output logic [IFM_W-1:0] ifm,
    input  logic             wgt_read,
    output logic [WGT_W-1:0] weight,
    output logic             busy,
    output logic             done,
    output logic             underflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic   start, run, ifm_all, wgt_all, ifm_uf, wgt_uf;

    assign start = (state == IDLE) && start_conv;
    assign run   = state == RUN;
    assign busy  = run;
    assign done  = state == DONE;

    conv_in_chan #(.W(IFM_W), .AW(FIFO_AW), .CW(CNT_W)) u_ifm (
        .clk(clk), .rst_n(rst_n), .clr(start), .run(run), .len_in(ifm_words),
        .s_data(ifm_s_data), .s_valid(ifm_s_valid), .s_ready(ifm_s_ready),
        .read(ifm_read), .dout(ifm), .all_served(ifm_all), .uflow(ifm_uf)
    );

    conv_in_chan #(.W(WGT_W), .AW(FIFO_AW), .CW(CNT_W)) u_wgt (
        .clk(clk), .rst_n(rst_n), .clr(start), .run(run), .len_in(wgt_words),
        .s_data(wgt_s_data), .s_valid(wgt_s_valid), .s_ready(wgt_s_ready),
        .read(wgt_read), .dout(weight), .all_served(wgt_all), .uflow(wgt_uf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_conv ? RUN : IDLE;
            RUN:     state_nx = (ifm_all && wgt_all) ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            underflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (start)                 underflow <= 1'b0;
            else if (ifm_uf || wgt_uf) underflow <= 1'b1;
        end
    end
endmodule
